// File: rtl/m_stage.sv
// ---------------------------------------------------------------------------
// m_stage : MEM stage of the 5-stage MIPS pipeline.
//
// Holds the E->M pipeline register (IR/PC/PC4/AO/RT) and the data memory.
// Stores (sw/sh/sb) are written at the posedge that ends the store's M cycle.
// Loads (lw/lh/lhu/lb/lbu) read combinationally from the registered address.
// Store data can be forwarded from the W stage.
//
// Optional feature macro: DM_ALIGN_CHECK_EN
//   defined   : misaligned word/half accesses raise misalign. Such a store
//               is suppressed and such a load returns 0.
//   undefined : misalign is tied to 0. The low address bits are ignored.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   instr/pc/pc4    E-stage IR, PC, PC+4
//   aluout, rt      E-stage effective address/result, store data
//   WD_W, PC4_W     W-stage write-back data and PC+4 (forwarding sources)
//   mf_RTout_M      store-data select: 0/3 = RT_M, 1 = WD_W, 2 = PC4_W+4
//   instr_out..     IR_M, PC_M, PC4_M, AO_M
//   dm_out          extended load data, 0 when IR_M is not a load
//   misalign        misaligned word/half access (only with the macro)
// ---------------------------------------------------------------------------
module m_stage #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic [31:0] aluout,
    input  logic [31:0] rt,
    input  logic [31:0] WD_W,
    input  logic [31:0] PC4_W,
    input  logic [1:0]  mf_RTout_M,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] ao_out,
    output logic [31:0] dm_out,
    output logic        misalign
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [31:0] ir_m, pc_m, pc4_m, ao_m, rt_m;

    // E->M pipeline register; no stall and no flush.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_m  <= '0;
            pc_m  <= '0;
            pc4_m <= '0;
            ao_m  <= '0;
            rt_m  <= '0;
        end else begin
            ir_m  <= instr;
            pc_m  <= pc;
            pc4_m <= pc4;
            ao_m  <= aluout;
            rt_m  <= rt;
        end
    end

    assign instr_out = ir_m;
    assign pc_out    = pc_m;
    assign pc4_out   = pc4_m;
    assign ao_out    = ao_m;

    // Decode
    logic [5:0] opcode;
    logic is_sw, is_sh, is_sb, is_lw, is_lh, is_lhu, is_lb, is_lbu;
    logic is_store;

    assign opcode   = ir_m[31:26];
    assign is_sw    = (opcode == OP_SW);
    assign is_sh    = (opcode == OP_SH);
    assign is_sb    = (opcode == OP_SB);
    assign is_lw    = (opcode == OP_LW);
    assign is_lh    = (opcode == OP_LH);
    assign is_lhu   = (opcode == OP_LHU);
    assign is_lb    = (opcode == OP_LB);
    assign is_lbu   = (opcode == OP_LBU);
    assign is_store = is_sw | is_sh | is_sb;

    // Upper address bits are dropped, so addresses wrap modulo DM_WORDS*4.
    logic [DM_AW-1:0] word_idx;
    logic [1:0]       byte_off;
    assign word_idx = ao_m[DM_AW+1:2];
    assign byte_off = ao_m[1:0];

    logic mis_access;
`ifdef DM_ALIGN_CHECK_EN
    assign mis_access = ((is_sw | is_lw) && (byte_off != 2'b00))
                      || ((is_sh | is_lh | is_lhu) && byte_off[0]);
`else
    assign mis_access = 1'b0;
`endif
    assign misalign = mis_access;

    // Store-data forward mux
    logic [31:0] sd;
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sd = rt_m;
        case (mf_RTout_M)
            2'd1:    sd = WD_W;
            2'd2:    sd = PC4_W + 32'd4;
            default: sd = rt_m;
        endcase
    end

    // Data memory
    logic [31:0] mem [DM_WORDS];
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic        store_en;

    assign rd_word  = mem[word_idx];
    assign store_en = is_store & ~mis_access;

    // Partial stores merge the new lanes into the current word contents.
    always_comb begin
        wr_word = rd_word;
        if (is_sw) begin
            wr_word = sd;
        end else if (is_sh) begin
            if (byte_off[1]) wr_word[31:16] = sd[15:0];
            else             wr_word[15:0]  = sd[15:0];
        end else if (is_sb) begin
            wr_word[8*byte_off +: 8] = sd[7:0];
        end
    end

    // NOTE: the memory is cleared by reset, so it is built from resettable
    // flops rather than a RAM macro; reset also drops any pending store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (store_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Load path: lane select and extension, little-endian lanes.
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    assign half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    assign byte_sel = rd_word[8*byte_off +: 8];

    always_comb begin
        dm_out = '0;
        if (!mis_access) begin
            if (is_lw)       dm_out = rd_word;
            else if (is_lh)  dm_out = {{16{half_sel[15]}}, half_sel};
            else if (is_lhu) dm_out = {16'h0000, half_sel};
            else if (is_lb)  dm_out = {{24{byte_sel[7]}}, byte_sel};
            else if (is_lbu) dm_out = {24'h000000, byte_sel};
        end
    end

endmodule

// File: tb/tb_m_stage.sv
// ---------------------------------------------------------------------------
// tb_m_stage : self-checking bench for m_stage.
// A byte-addressed reference memory plus a copy of the M-stage contents give
// the expected outputs. Directed cases pin the reference, then a random
// instruction stream is compared against it every cycle.
// ---------------------------------------------------------------------------
module tb_m_stage;

    localparam int DM_WORDS = 1024;
    localparam int BYTES    = DM_WORDS * 4;

    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25,
                           OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc, pc4, aluout, rt, WD_W, PC4_W;
    logic [1:0]  mf_RTout_M;
    logic [31:0] instr_out, pc_out, pc4_out, ao_out, dm_out;
    logic        misalign;

    m_stage #(.DM_WORDS(DM_WORDS), .DM_AW(10)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .pc4(pc4),
        .aluout(aluout), .rt(rt), .WD_W(WD_W), .PC4_W(PC4_W),
        .mf_RTout_M(mf_RTout_M), .instr_out(instr_out), .pc_out(pc_out),
        .pc4_out(pc4_out), .ao_out(ao_out), .dm_out(dm_out),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [BYTES];
    logic [31:0] m_ir, m_pc, m_pc4, m_ao, m_rt;

    task automatic model_clear();
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
        m_ir = 0; m_pc = 0; m_pc4 = 0; m_ao = 0; m_rt = 0;
    endtask

    function automatic bit model_mis();
        logic [5:0] op = m_ir[31:26];
`ifdef DM_ALIGN_CHECK_EN
        if ((op == OP_SW || op == OP_LW) && (m_ao % 4) != 0) return 1'b1;
        if ((op == OP_SH || op == OP_LH || op == OP_LHU) && (m_ao % 2) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_dm();
        logic [5:0]  op = m_ir[31:26];
        int          a  = int'(m_ao % BYTES);
        int          wb = a - (a % 4);
        int          hb = a - (a % 2);
        logic [15:0] h  = {mb[hb+1], mb[hb]};
        logic [7:0]  b  = mb[a];
        if (model_mis()) return 32'h0;
        case (op)
            OP_LW:   return {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    // Applies the store in M (if any) and then advances the pipeline register.
    task automatic model_edge();
        logic [5:0]  op = m_ir[31:26];
        int          a  = int'(m_ao % BYTES);
        logic [31:0] sd;
        case (mf_RTout_M)
            2'd1:    sd = WD_W;
            2'd2:    sd = PC4_W + 4;
            default: sd = m_rt;
        endcase
        if (!model_mis()) begin
            if (op == OP_SW) begin
                for (int k = 0; k < 4; k++) mb[a - (a % 4) + k] = sd[8*k +: 8];
            end else if (op == OP_SH) begin
                mb[a - (a % 2)]     = sd[7:0];
                mb[a - (a % 2) + 1] = sd[15:8];
            end else if (op == OP_SB) begin
                mb[a] = sd[7:0];
            end
        end
        m_ir = instr; m_pc = pc; m_pc4 = pc4; m_ao = aluout; m_rt = rt;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("instr_out", instr_out, m_ir);
            check("pc_out",    pc_out,    m_pc);
            check("pc4_out",   pc4_out,   m_pc4);
            check("ao_out",    ao_out,    m_ao);
            check("dm_out",    dm_out,    model_dm());
            check("misalign",  {31'b0, misalign}, {31'b0, model_mis()});
        end
    end

    // One clock: present the next E-stage instruction, cross the edge,
    // then settle at the falling edge.
    task automatic cyc(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d);
        instr  = {op, 26'($urandom)};
        pc     = $urandom;
        pc4    = pc + 4;
        aluout = a;
        rt     = d;
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 10))
            0:  return OP_SW;  1: return OP_SH;  2: return OP_SB;
            3:  return OP_LW;  4: return OP_LH;  5: return OP_LHU;
            6:  return OP_LB;  7: return OP_LBU;
            8:  return 6'h00;  9: return 6'h08;
            default: return 6'h0F;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        instr = {OP_SW, 26'h0}; pc = 0; pc4 = 4; aluout = 0; rt = 32'hDEADBEEF;
        WD_W = 0; PC4_W = 0; mf_RTout_M = 2'd0;
        model_clear();
        // 1. reset with a store presented
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc",    pc_out,    32'h0);
        check("rst_pc4",   pc4_out,   32'h0);
        check("rst_ao",    ao_out,    32'h0);
        check("rst_dm",    dm_out,    32'h0);
        check("rst_mis",   {31'b0, misalign}, 32'h0);
        reset = 1'b0;
        cmp_en = 1'b1;
        cyc(OP_LW, 32'h0, 0);
        check("mem0_after_reset", dm_out, 32'h0);

        // 2. sw then lw
        cyc(OP_SW, 32'h10, 32'h89ABCDEF);
        cyc(OP_LW, 32'h10, 0);
        check("sw_lw", dm_out, 32'h89ABCDEF);

        // 3. sb into byte 1, then signed/unsigned byte loads
        cyc(OP_SB, 32'h11, 32'h55);
        cyc(OP_LW, 32'h10, 0);
        check("sb_word", dm_out, 32'h89AB55EF);
        cyc(OP_LB, 32'h13, 0);
        check("lb_sext", dm_out, 32'hFFFFFF89);
        cyc(OP_LBU, 32'h13, 0);
        check("lbu_zext", dm_out, 32'h00000089);

        // 4. sh with WD_W forwarded
        cyc(OP_SH, 32'h22, 32'h1);
        mf_RTout_M = 2'd1; WD_W = 32'h0000F00D;
        cyc(OP_LH, 32'h22, 0);
        mf_RTout_M = 2'd0;
        check("lh_sext", dm_out, 32'hFFFFF00D);
        cyc(OP_LHU, 32'h22, 0);
        check("lhu_zext", dm_out, 32'h0000F00D);
        cyc(OP_LW, 32'h20, 0);
        check("sh_word", dm_out, 32'hF00D0000);

        // PC4_W+4 forwarding
        cyc(OP_SW, 32'h30, 32'h0);
        mf_RTout_M = 2'd2; PC4_W = 32'h100;
        cyc(OP_LW, 32'h30, 0);
        mf_RTout_M = 2'd0;
        check("fwd_pc4w", dm_out, 32'h104);

        // 5. address wrap
        cyc(OP_SW, 32'h1004, 32'h12345678);
        cyc(OP_LW, 32'h4, 0);
        check("wrap", dm_out, 32'h12345678);

        // 6. misaligned word store/load
        cyc(OP_SW, 32'h6, 32'hCAFEBABE);
`ifdef DM_ALIGN_CHECK_EN
        check("mis_sw_flag", {31'b0, misalign}, 32'h1);
`else
        check("mis_sw_flag", {31'b0, misalign}, 32'h0);
`endif
        cyc(OP_LW, 32'h4, 0);
`ifdef DM_ALIGN_CHECK_EN
        check("mis_sw_nowrite", dm_out, 32'h12345678);
`else
        check("mis_sw_trunc", dm_out, 32'hCAFEBABE);
`endif
        cyc(OP_LW, 32'h6, 0);
`ifdef DM_ALIGN_CHECK_EN
        check("mis_lw", dm_out, 32'h0);
`else
        check("mis_lw", dm_out, 32'hCAFEBABE);
`endif

        // Random stream over a few hot words at both ends of memory
        for (int n = 0; n < 1500; n++) begin
            a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7))
                                            : 32'($urandom_range(1020, 1023));
            a = (a << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & ~32'(BYTES - 1));
            mf_RTout_M = 2'($urandom);
            WD_W       = $urandom;
            PC4_W      = $urandom;
            if (n == 700) begin
                // Asynchronous reset mid-cycle drops the store currently in M.
                reset = 1'b1;
                #1;
                model_clear();
                cyc(OP_SW, a, $urandom);
                reset = 1'b0;
            end else begin
                cyc(rand_op(), a, $urandom);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
